// File: rtl/median_window_feeder_if.sv
// Signal bundle between the 3x3 median window feeder and its neighbours:
// pixel source, downstream median stage and filtered-pixel sink.
interface median_window_feeder_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             med_nrst;
    logic [WIDTH-1:0] med_di;
    logic             med_dsi;
    logic [WIDTH-1:0] med_do;
    logic             med_dso;
    logic [WIDTH-1:0] out_pix;
    logic             out_valid;
    logic             frame_done;
    logic             err;

    // master: environment (pixel source, median stage, sink); slave: the feeder
    modport master (
        output pix_in, pix_valid, med_do, med_dso,
        input  pix_ready, med_nrst, med_di, med_dsi, out_pix, out_valid, frame_done, err
    );
    modport slave (
        input  pix_in, pix_valid, med_do, med_dso,
        output pix_ready, med_nrst, med_di, med_dsi, out_pix, out_valid, frame_done, err
    );
endinterface

// File: rtl/median_window_feeder.sv
// Buffers three image lines and streams each interior 3x3 window to an
// external median stage, returning one filtered pixel per window.
module median_window_feeder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    median_window_feeder_if.slave bus
);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned LINE_W = $clog2(ROWS + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned K_W    = 4;

    typedef enum logic [2:0] {S_FILL, S_MRST, S_BURST, S_WAIT, S_EMIT} state_e;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  c_q, c_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [1:0]        wr_line_q, wr_line_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pix_ready_q, pix_ready_d;
    logic              med_nrst_q, med_nrst_d;
    logic              med_dsi_q, med_dsi_d;
    logic [WIDTH-1:0]  med_di_q, med_di_d;
    logic [WIDTH-1:0]  out_pix_q, out_pix_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  line_buf [3][COLS];

    logic              xfer, line_end, row_last, frame_last;
    logic [K_W-1:0]    s_idx;
    logic [1:0]        s_row, s_off, s_slot;
    logic [2:0]        s_sum;
    logic [COL_W-1:0]  s_col;

    assign xfer       = bus.pix_valid & pix_ready_q;
    assign line_end   = xfer && (col_q == COL_W'(COLS - 1));
    assign row_last   = (c_q == COL_W'(COLS - 2));
    assign frame_last = row_last && (line_q == LINE_W'(ROWS));

    // Newest line lands in the oldest slot; no reset needed, pointers define validity.
    always_ff @(posedge clk) begin
        if (xfer) begin
            line_buf[wr_line_q][col_q] <= bus.pix_in;
        end
    end

    // Window sample for the next burst cycle; top line sits at the write pointer slot.
    always_comb begin
        s_idx = ((state_q == S_BURST) && (k_q < K_W'(8))) ? k_q + K_W'(1) : '0;
        if (s_idx < K_W'(3)) begin
            s_row = 2'd0;
        end else if (s_idx < K_W'(6)) begin
            s_row = 2'd1;
        end else begin
            s_row = 2'd2;
        end
        s_off  = 2'(s_idx - K_W'(3) * K_W'(s_row));
        s_sum  = 3'(wr_line_q) + 3'(s_row);
        s_slot = (s_sum >= 3'd3) ? 2'(s_sum - 3'd3) : 2'(s_sum);
        s_col  = c_q - COL_W'(1) + COL_W'(s_off);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            c_q          <= COL_W'(1);
            line_q       <= '0;
            wr_line_q    <= '0;
            k_q          <= '0;
            wait_q       <= '0;
            pix_ready_q  <= 1'b0;
            med_nrst_q   <= 1'b0;
            med_dsi_q    <= 1'b0;
            med_di_q     <= '0;
            out_pix_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            c_q          <= c_d;
            line_q       <= line_d;
            wr_line_q    <= wr_line_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            pix_ready_q  <= pix_ready_d;
            med_nrst_q   <= med_nrst_d;
            med_dsi_q    <= med_dsi_d;
            med_di_q     <= med_di_d;
            out_pix_q    <= out_pix_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (line_end && (line_q >= LINE_W'(2))) state_d = S_MRST;
            S_MRST:  state_d = S_BURST;
            S_BURST: if (k_q == K_W'(8)) state_d = S_WAIT;
            S_WAIT:  if (bus.med_dso || (wait_q == WAIT_W'(TIMEOUT - 1))) state_d = S_EMIT;
            S_EMIT:  state_d = row_last ? S_FILL : S_MRST;
            default: state_d = S_FILL;
        endcase
    end

    // Counters, result capture and outputs registered against the next state.
    always_comb begin
        col_d        = col_q;
        c_d          = c_q;
        line_d       = line_q;
        wr_line_d    = wr_line_q;
        k_d          = k_q;
        wait_d       = '0;
        med_di_d     = med_di_q;
        out_pix_d    = out_pix_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        if (xfer) begin
            if (col_q == COL_W'(COLS - 1)) begin
                col_d     = '0;
                line_d    = line_q + LINE_W'(1);
                wr_line_d = (wr_line_q == 2'd2) ? 2'd0 : wr_line_q + 2'd1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            S_MRST:  k_d = '0;
            S_BURST: k_d = k_q + K_W'(1);
            S_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (bus.med_dso) begin
                    out_pix_d = bus.med_do;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    out_pix_d = '0;
                    err_d     = 1'b1;
                end
            end
            S_EMIT: begin
                if (row_last) begin
                    c_d = COL_W'(1);
                    if (frame_last) begin
                        line_d       = '0;
                        wr_line_d    = '0;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    c_d = c_q + COL_W'(1);
                end
            end
            default: ;
        endcase

        if (state_d == S_BURST) begin
            med_di_d = line_buf[s_slot][s_col];
        end

        pix_ready_d = (state_d == S_FILL);
        med_nrst_d  = (state_d != S_MRST);
        med_dsi_d   = (state_d == S_BURST);
        out_valid_d = (state_d == S_EMIT);
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.med_nrst   = med_nrst_q;
    assign bus.med_dsi    = med_dsi_q;
    assign bus.med_di     = med_di_q;
    assign bus.out_pix    = out_pix_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_median_window_feeder.sv
// Random-stimulus bench for median_window_feeder with an emulated median stage
// and a frame-level reference model of the expected windows and medians.
module tb_median_window_feeder;
    localparam int W   = 8;
    localparam int C   = 4;
    localparam int R   = 4;
    localparam int TMO = 16;

    typedef struct {
        int pix;
        bit err;
        bit tmo;
    } want_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    median_window_feeder_if #(.WIDTH(W)) bus ();

    median_window_feeder #(.WIDTH(W), .COLS(C), .ROWS(R), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    pix_q[$];
    int    want_di_q[$];
    want_t want_q[$];
    int    frame_px [R][C];
    bit    rand_valid = 1'b0;
    bit    want_err = 1'b0;
    int    suppress_n = 0;
    int    fd_cnt = 0;
    int    ov_cnt = 0;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int median9(input int v[9]);
        int s[9];
        int t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    // Reference: every interior pixel's 3x3 neighbourhood in raster order.
    task automatic plan_frame(input int tmo_w);
        int    win[9];
        int    idx;
        want_t e;
        idx = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                pix_q.push_back(frame_px[r][c]);
        if (tmo_w > 0) want_err = 1'b1;
        for (int r = 1; r < R - 1; r++)
            for (int c = 1; c < C - 1; c++) begin
                for (int k = 0; k < 9; k++) begin
                    win[k] = frame_px[r - 1 + k / 3][c - 1 + k % 3];
                    want_di_q.push_back(win[k]);
                end
                e.tmo = (idx < tmo_w);
                e.pix = e.tmo ? 0 : median9(win);
                e.err = want_err;
                want_q.push_back(e);
                idx++;
            end
    endtask

    task automatic run_frames(input int nfr, input bit rv, input bit ramp, input int tmo_w);
        int target;
        target = fd_cnt + nfr;
        rand_valid = rv;
        suppress_n = tmo_w;
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    frame_px[r][c] = ramp ? r * C + c : int'($urandom_range(0, 255));
            plan_frame(f == 0 ? tmo_w : 0);
        end
        for (int i = 0; i < 4000 && fd_cnt < target; i++) @(negedge clk);
        check_eq("frame_done_count", fd_cnt, target);
        check_eq("outputs_left", want_q.size(), 0);
    endtask

    // Pixel source: offers the queue head, optionally with random valid gaps.
    initial begin
        bit rdy_prev;
        rdy_prev = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        forever begin
            @(negedge clk);
            if (bus.pix_valid && rdy_prev && pix_q.size() > 0) void'(pix_q.pop_front());
            if (pix_q.size() > 0 && (!rand_valid || $urandom_range(0, 1) == 1)) begin
                bus.pix_valid = 1'b1;
                bus.pix_in    = W'(pix_q[0]);
            end else begin
                bus.pix_valid = 1'b0;
                bus.pix_in    = W'($urandom);
            end
            rdy_prev = bus.pix_ready;
        end
    end

    // Output monitor plus emulated median stage (level-held result until restart).
    initial begin
        int    cyc, last_dsi, dsi_run, outs_in_frame, lat, n_samp;
        bit    prev_ov, prev_fd;
        int    win[9];
        want_t e;
        cyc = 0; last_dsi = 0; dsi_run = 0; outs_in_frame = 0; lat = -1; n_samp = 0;
        prev_ov = 1'b0; prev_fd = 1'b0;
        bus.med_do  = '0;
        bus.med_dso = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                dsi_run = 0; outs_in_frame = 0; prev_ov = 1'b0; prev_fd = 1'b0;
            end else begin
                if (!bus.med_nrst || bus.med_dsi || bus.out_valid)
                    check_eq("ready_while_busy", int'(bus.pix_ready), 0);
                if (bus.med_dsi) begin
                    dsi_run++;
                    last_dsi = cyc;
                    check_eq("di_expected", int'(want_di_q.size() > 0), 1);
                    if (want_di_q.size() > 0) check_eq("med_di", int'(bus.med_di), want_di_q.pop_front());
                end else begin
                    if (dsi_run != 0) check_eq("burst_len", dsi_run, 9);
                    dsi_run = 0;
                end
                if (bus.out_valid) begin
                    ov_cnt++;
                    outs_in_frame++;
                    check_eq("out_expected", int'(want_q.size() > 0), 1);
                    if (want_q.size() > 0) begin
                        e = want_q.pop_front();
                        check_eq("out_pix", int'(bus.out_pix), e.pix);
                        check_eq("err_at_out", int'(bus.err), int'(e.err));
                        if (e.tmo) check_eq("timeout_latency", cyc - last_dsi, TMO + 1);
                    end
                end
                if (bus.frame_done) begin
                    fd_cnt++;
                    check_eq("fd_after_last_out", int'(prev_ov && outs_in_frame == (R - 2) * (C - 2)), 1);
                    check_eq("fd_one_cycle", int'(prev_fd), 0);
                    outs_in_frame = 0;
                end
                prev_ov = bus.out_valid;
                prev_fd = bus.frame_done;
            end

            if (!bus.med_nrst) begin
                n_samp = 0; lat = -1;
                bus.med_dso = 1'b0;
                bus.med_do  = W'($urandom);
            end else if (bus.med_dsi) begin
                if (n_samp < 9) win[n_samp] = int'(bus.med_di);
                n_samp++;
                if (n_samp == 9) lat = int'($urandom_range(0, 4));
            end else if (lat > 0) begin
                lat--;
            end else if (lat == 0) begin
                lat = -1;
                if (suppress_n > 0) suppress_n--;
                else begin
                    bus.med_do  = W'(median9(win));
                    bus.med_dso = 1'b1;
                end
            end
        end
    end

    initial begin
        int ov_before;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_pix_ready", int'(bus.pix_ready), 0);
        check_eq("rst_med_nrst", int'(bus.med_nrst), 0);
        check_eq("rst_med_dsi", int'(bus.med_dsi), 0);
        check_eq("rst_med_di", int'(bus.med_di), 0);
        check_eq("rst_out_pix", int'(bus.out_pix), 0);
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_frame_done", int'(bus.frame_done), 0);
        check_eq("rst_err", int'(bus.err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_ready", int'(bus.pix_ready), 1);
        check_eq("post_rst_nrst", int'(bus.med_nrst), 1);

        run_frames(1, 1'b0, 1'b1, 0);   // ramp frame, continuous valid
        run_frames(1, 1'b1, 1'b1, 0);   // ramp frame, gappy valid
        run_frames(1, 1'b1, 1'b0, 0);   // random pixels
        run_frames(2, 1'b1, 1'b0, 0);   // back-to-back frames
        run_frames(1, 1'b1, 1'b0, 1);   // first window times out
        check_eq("err_sticky", int'(bus.err), 1);

        // Abort in the middle of a burst
        rand_valid = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                frame_px[r][c] = r * C + c;
        plan_frame(0);
        for (int i = 0; i < 500 && !bus.med_dsi; i++) @(negedge clk);
        check_eq("burst_seen", int'(bus.med_dsi), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        ov_before = ov_cnt;
        @(negedge clk);
        check_eq("abort_dsi", int'(bus.med_dsi), 0);
        check_eq("abort_out_valid", int'(bus.out_valid), 0);
        pix_q.delete();
        want_di_q.delete();
        want_q.delete();
        want_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("abort_no_output", ov_cnt, ov_before);
        check_eq("err_cleared", int'(bus.err), 0);

        run_frames(1, 1'b0, 1'b1, 0);   // fresh frame after abort

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 Parameter WIDTH, default 8, pixel bit width.
REQ-002 Parameter COLS, default 16, pixels per image line (>=3).
REQ-003 Parameter ROWS, default 16, lines per frame (>=3).
REQ-004 Parameter TIMEOUT, default 64, max cycles waiting for MED_DSO.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 PIX_IN  in  WIDTH  raster-order input pixel.
REQ-008 PIX_VALID  in  1  PIX_IN valid.
REQ-009 PIX_READY  out  1  block accepts a pixel this cycle.
REQ-010 MED_NRST  out  1  active-low restart to downstream median stage.
REQ-011 MED_DI  out  WIDTH  window sample to median stage.
REQ-012 MED_DSI  out  1  MED_DI valid.
REQ-013 MED_DO  in  WIDTH  median result.
REQ-014 MED_DSO  in  1  median result valid (level, held until restart).
REQ-015 OUT_PIX  out  WIDTH  filtered pixel.
REQ-016 OUT_VALID  out  1  one-cycle strobe, OUT_PIX valid.
REQ-017 FRAME_DONE  out  1  one-cycle strobe after last filtered pixel of a frame.
REQ-018 ERR  out  1  sticky timeout flag.

Function
REQ-019 Pixel transfer SHALL occur on cycles with PIX_VALID=1 and PIX_READY=1; other cycles leave storage unchanged.
REQ-020 Storage SHALL be three COLS-deep line buffers used circularly; the newest line overwrites the oldest.
REQ-021 FSM states SHALL be FILL, MRST, BURST, WAIT, EMIT.
REQ-022 FILL: PIX_READY=1; column counter increments per transfer, wraps COLS-1 -> 0 and increments line counter.
REQ-023 FILL SHALL exit to MRST on a line-completing transfer once line counter reaches >=3 lines stored (i.e. lines 2..ROWS-1 completed); otherwise remain in FILL.
REQ-024 PIX_READY SHALL be 0 in every state other than FILL.
REQ-025 MRST: exactly one cycle with MED_NRST=0, then BURST; MED_NRST=1 in all other states.
REQ-026 BURST: exactly 9 consecutive cycles MED_DSI=1, MED_DI = window sample k=0..8, row-major from top-left (top line c-1,c,c+1; middle; bottom), window centre column c; then WAIT.
REQ-027 MED_DSI SHALL be 0 outside BURST; MED_DI value outside BURST is don't-care.
REQ-028 WAIT: on first cycle MED_DSO=1, register MED_DO into OUT_PIX and go to EMIT; a wait counter starts at 0 on entry.
REQ-029 If the wait counter reaches TIMEOUT without MED_DSO, ERR SHALL be set to 1, OUT_PIX=0, and go to EMIT.
REQ-030 EMIT: OUT_VALID=1 for one cycle; centre column advances c=1..COLS-2; if c<COLS-2 go to MRST with c+1, else back to FILL with c=1.
REQ-031 Output SHALL be interior pixels only: (ROWS-2)*(COLS-2) OUT_VALID strobes per frame, raster order.
REQ-032 FRAME_DONE SHALL pulse in the cycle after the EMIT of window (row ROWS-2, col COLS-2); line counter and buffers' write pointer return to 0, next frame starts in FILL.
REQ-033 MED_DSO sampled in any state other than WAIT SHALL be ignored.
REQ-034 ERR SHALL stay 1 until RST; processing continues normally after a timeout.

Reset
REQ-035 RST=1 on a rising edge SHALL force: state FILL, all counters 0, c=1, PIX_READY=0 during reset then 1, MED_NRST=0, MED_DSI=0, MED_DI=0, OUT_PIX=0, OUT_VALID=0, FRAME_DONE=0, ERR=0.
REQ-036 RST mid-burst or mid-wait SHALL abort the window with no OUT_VALID; buffer contents are treated as empty.

Verification
REQ-037 COLS=ROWS=4, frame pixels 0..15 continuous -> first burst after pixel 11: MED_DI = 0,1,2,4,5,6,8,9,10 with MED_DSI high 9 cycles.
REQ-038 Same frame with behavioural median model -> OUT_PIX sequence 5,6,9,10, four OUT_VALID strobes, FRAME_DONE one cycle after fourth.
REQ-039 PIX_VALID toggled 50% randomly -> identical output sequence; PIX_READY=0 throughout MRST/BURST/WAIT/EMIT.
REQ-040 MED_DSO held 0 -> ERR=1 after TIMEOUT wait cycles, OUT_VALID with OUT_PIX=0, next window still issued.
REQ-041 RST asserted at BURST cycle 4 -> MED_DSI=0 next cycle, no OUT_VALID, fresh frame afterwards reproduces REQ-038 output.
REQ-042 Two back-to-back frames -> 8 OUT_VALID, two FRAME_DONE, second frame outputs independent of first.
